// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocate / complete / retire / free-list signal bundle
// between rename, the execution units and the reorder buffer.
// master = rename/execute side, slave = reorder buffer.
interface reorder_buffer_if #(
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5,
    parameter int IDX_WIDTH  = 4
);
    // Allocation from rename
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic                  alloc_has_rd;
    logic [AREG_WIDTH-1:0] alloc_areg;
    logic [PREG_WIDTH-1:0] alloc_rrd;
    logic [PREG_WIDTH-1:0] alloc_old_rd;
    logic [11:0]           alloc_pc;
    logic [IDX_WIDTH-1:0]  alloc_idx;

    // Completion from execution
    logic                  complete_valid;
    logic [IDX_WIDTH-1:0]  complete_idx;

    // Free-list return and retirement trace
    logic                  push_free_reg;
    logic [PREG_WIDTH-1:0] freed_reg;
    logic                  retire_valid;
    logic [AREG_WIDTH-1:0] retire_areg;
    logic [PREG_WIDTH-1:0] retire_rrd;
    logic [11:0]           retire_pc;

    // Occupancy
    logic [IDX_WIDTH:0]    count;
    logic                  empty;

    modport master (
        output alloc_valid, alloc_has_rd, alloc_areg, alloc_rrd, alloc_old_rd, alloc_pc,
        output complete_valid, complete_idx,
        input  alloc_ready, alloc_idx,
        input  push_free_reg, freed_reg,
        input  retire_valid, retire_areg, retire_rrd, retire_pc,
        input  count, empty
    );

    modport slave (
        input  alloc_valid, alloc_has_rd, alloc_areg, alloc_rrd, alloc_old_rd, alloc_pc,
        input  complete_valid, complete_idx,
        output alloc_ready, alloc_idx,
        output push_free_reg, freed_reg,
        output retire_valid, retire_areg, retire_rrd, retire_pc,
        output count, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue beside rename. Entries are
// allocated at the tail, marked done by index, and retired from the head one
// per cycle; a retiring entry's previous mapping goes back to the free list
// unless it is tag 0 (x0) or the instruction had no destination.
// Optional feature: define ROB_FLUSH_EN to add a synchronous `flush` input.
module reorder_buffer #(
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input logic clk,
    input logic rst,
`ifdef ROB_FLUSH_EN
    input logic flush,
`endif
    reorder_buffer_if.slave rob
);
    localparam logic [IDX_WIDTH:0] PTR_ONE = (IDX_WIDTH+1)'(1);

    // Pointers carry a wrap bit above the index bits
    logic [IDX_WIDTH:0] head, tail, count_q;
    logic [IDX_WIDTH-1:0] head_idx, tail_idx;

    // Per-entry control state (reset) and payload (not reset)
    logic [DEPTH-1:0]      valid_q, done_q, has_rd_q;
    logic [AREG_WIDTH-1:0] areg_q   [DEPTH];
    logic [PREG_WIDTH-1:0] rrd_q    [DEPTH];
    logic [PREG_WIDTH-1:0] old_rd_q [DEPTH];
    logic [11:0]           pc_q     [DEPTH];

    // Registered retirement outputs
    logic                  retire_valid_q, push_free_q;
    logic [AREG_WIDTH-1:0] retire_areg_q;
    logic [PREG_WIDTH-1:0] retire_rrd_q, freed_q;
    logic [11:0]           retire_pc_q;

    logic full, alloc_fire, retire_fire, flush_w;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign head_idx    = head[IDX_WIDTH-1:0];
    assign tail_idx    = tail[IDX_WIDTH-1:0];
    assign full        = (head_idx == tail_idx) && (head[IDX_WIDTH] != tail[IDX_WIDTH]);
    assign alloc_fire  = rob.alloc_valid && !full;
    // done is read from the register, so a completion never retires on its own edge
    assign retire_fire = valid_q[head_idx] && done_q[head_idx];

    assign rob.alloc_ready   = !full;
    assign rob.alloc_idx     = tail_idx;
    assign rob.count         = count_q;
    assign rob.empty         = (head == tail);
    assign rob.retire_valid  = retire_valid_q;
    assign rob.retire_areg   = retire_areg_q;
    assign rob.retire_rrd    = retire_rrd_q;
    assign rob.retire_pc     = retire_pc_q;
    assign rob.push_free_reg = push_free_q;
    assign rob.freed_reg     = freed_q;

    // Pointer, occupancy and valid/done bookkeeping
    // NOTE: sequential state uses <= so every block sees pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush_w) begin
            tail    <= head;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // Completion to an unallocated entry (including one being allocated now) is dropped
            if (rob.complete_valid && valid_q[rob.complete_idx])
                done_q[rob.complete_idx] <= 1'b1;
            if (retire_fire) begin
                valid_q[head_idx] <= 1'b0;
                head              <= head + PTR_ONE;
            end
            // Allocation and retirement never touch the same slot: full blocks allocation,
            // empty has no valid head.
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail              <= tail + PTR_ONE;
            end
            unique case ({alloc_fire, retire_fire})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload capture at allocation
    // NOTE: payload storage is deliberately not reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[tail_idx] <= rob.alloc_has_rd;
            areg_q[tail_idx]   <= rob.alloc_areg;
            rrd_q[tail_idx]    <= rob.alloc_rrd;
            old_rd_q[tail_idx] <= rob.alloc_old_rd;
            pc_q[tail_idx]     <= rob.alloc_pc;
        end
    end

    // Registered retire trace and free-list return, one pulse per retirement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_valid_q <= 1'b0;
            retire_areg_q  <= '0;
            retire_rrd_q   <= '0;
            retire_pc_q    <= '0;
            push_free_q    <= 1'b0;
            freed_q        <= '0;
        end else if (flush_w || !retire_fire) begin
            retire_valid_q <= 1'b0;
            retire_areg_q  <= '0;
            retire_rrd_q   <= '0;
            retire_pc_q    <= '0;
            push_free_q    <= 1'b0;
            freed_q        <= '0;
        end else begin
            retire_valid_q <= 1'b1;
            retire_areg_q  <= areg_q[head_idx];
            retire_rrd_q   <= rrd_q[head_idx];
            retire_pc_q    <= pc_q[head_idx];
            // Tag 0 is x0's permanent mapping and must never reach the free list
            if (has_rd_q[head_idx] && (old_rd_q[head_idx] != '0)) begin
                push_free_q <= 1'b1;
                freed_q     <= old_rd_q[head_idx];
            end else begin
                push_free_q <= 1'b0;
                freed_q     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus for reorder_buffer with a scoreboard.
// Allocation pushes the expected retirement record; a monitor pops and
// compares on every retire_valid pulse. Define ROB_FLUSH_EN to also cover flush.
module tb_reorder_buffer;
    logic clk;
    logic rst;
`ifdef ROB_FLUSH_EN
    logic flush;
`endif

    reorder_buffer_if #(.PREG_WIDTH(6), .AREG_WIDTH(5), .IDX_WIDTH(4)) rob_bus ();

    reorder_buffer #(.PREG_WIDTH(6), .AREG_WIDTH(5), .DEPTH(16), .IDX_WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .rob  (rob_bus)
    );

    typedef struct {
        logic [4:0]  areg;
        logic [5:0]  rrd;
        logic [11:0] pc;
        logic        push;
        logic [5:0]  freed;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [4:0] exp_tail;   // model tail pointer incl. wrap bit

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every retirement against the oldest expected record
    always @(posedge clk) begin
        #2;
        if (rob_bus.push_free_reg && !rob_bus.retire_valid)
            check("push_without_retire", 1, 0);
        if (rob_bus.retire_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("retire_areg", rob_bus.retire_areg, e.areg);
                check("retire_rrd", rob_bus.retire_rrd, e.rrd);
                check("retire_pc", rob_bus.retire_pc, e.pc);
                check("push_free_reg", rob_bus.push_free_reg, e.push);
                if (e.push)
                    check("freed_reg", rob_bus.freed_reg, e.freed);
            end
        end
    end

    // Drive one allocation for the coming edge and record its expected retirement
    task automatic alloc_drive(input logic has_rd, input logic [4:0] areg,
                               input logic [5:0] rrd, input logic [5:0] old_rd,
                               input logic [11:0] pc);
        exp_t e;
        check("alloc_ready", rob_bus.alloc_ready, 1);
        check("alloc_idx", rob_bus.alloc_idx, exp_tail[3:0]);
        rob_bus.alloc_valid  = 1'b1;
        rob_bus.alloc_has_rd = has_rd;
        rob_bus.alloc_areg   = areg;
        rob_bus.alloc_rrd    = rrd;
        rob_bus.alloc_old_rd = old_rd;
        rob_bus.alloc_pc     = pc;
        e.areg  = areg;
        e.rrd   = rrd;
        e.pc    = pc;
        e.push  = has_rd && (old_rd != 6'd0);
        e.freed = old_rd;
        sb.push_back(e);
        exp_tail = exp_tail + 5'd1;
    endtask

    task automatic do_alloc(input logic has_rd, input logic [4:0] areg,
                            input logic [5:0] rrd, input logic [5:0] old_rd,
                            input logic [11:0] pc);
        alloc_drive(has_rd, areg, rrd, old_rd, pc);
        @(negedge clk);
        rob_bus.alloc_valid = 1'b0;
    endtask

    task automatic do_complete(input logic [3:0] idx);
        rob_bus.complete_valid = 1'b1;
        rob_bus.complete_idx   = idx;
        @(negedge clk);
        rob_bus.complete_valid = 1'b0;
    endtask

    // Bounded wait for all expected retirements and an empty buffer
    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && rob_bus.empty) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, ok, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        exp_tail = 5'd0;
    endtask

    initial begin
        logic [3:0] prev_idx;
        logic [3:0] seen_idx;
        int         wraps;
        logic [4:0] head_model;

        rst = 1'b0;
        exp_tail = 5'd0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        rob_bus.alloc_valid    = 1'b0;
        rob_bus.alloc_has_rd   = 1'b0;
        rob_bus.alloc_areg     = '0;
        rob_bus.alloc_rrd      = '0;
        rob_bus.alloc_old_rd   = '0;
        rob_bus.alloc_pc       = '0;
        rob_bus.complete_valid = 1'b0;
        rob_bus.complete_idx   = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_empty", rob_bus.empty, 1);
        check("rst_count", rob_bus.count, 0);
        check("rst_alloc_ready", rob_bus.alloc_ready, 1);
        check("rst_alloc_idx", rob_bus.alloc_idx, 0);
        check("rst_retire_valid", rob_bus.retire_valid, 0);
        check("rst_push_free", rob_bus.push_free_reg, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single instruction: retire pulse appears after the edge following completion
        do_alloc(1'b1, 5'd3, 6'd33, 6'd5, 12'h100);
        check("count_one", rob_bus.count, 1);
        do_complete(4'd0);
        check("no_bypass_retire", rob_bus.retire_valid, 0);
        @(negedge clk);
        check("t1_retire_valid", rob_bus.retire_valid, 1);
        check("t1_push", rob_bus.push_free_reg, 1);
        check("t1_freed", rob_bus.freed_reg, 5);
        check("t1_rrd", rob_bus.retire_rrd, 33);
        @(negedge clk);
        check("t1_pulse_end", rob_bus.retire_valid, 0);
        check("t1_push_end", rob_bus.push_free_reg, 0);
        check("t1_empty", rob_bus.empty, 1);

        // Allocate and complete the same index in one cycle: completion dropped
        rob_bus.complete_valid = 1'b1;
        rob_bus.complete_idx   = 4'd1;
        do_alloc(1'b1, 5'd4, 6'd34, 6'd6, 12'h101);
        rob_bus.complete_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("same_cycle_no_retire", rob_bus.retire_valid, 0);
        end
        check("same_cycle_count", rob_bus.count, 1);
        do_complete(4'd1);
        wait_drain("drain_same_cycle");

        // Out-of-order completion, in-order retirement
        do_alloc(1'b1, 5'd7, 6'd35, 6'd8, 12'h110);
        do_alloc(1'b1, 5'd8, 6'd36, 6'd9, 12'h111);
        do_alloc(1'b1, 5'd9, 6'd37, 6'd10, 12'h112);
        do_complete(4'd4);
        check("ooo_hold_a", rob_bus.retire_valid, 0);
        do_complete(4'd3);
        check("ooo_hold_b", rob_bus.retire_valid, 0);
        do_complete(4'd2);
        check("ooo_hold_c", rob_bus.retire_valid, 0);
        @(negedge clk);
        check("ooo_ret0", rob_bus.retire_valid, 1);
        check("ooo_pc0", rob_bus.retire_pc, 12'h110);
        @(negedge clk);
        check("ooo_ret1", rob_bus.retire_valid, 1);
        check("ooo_pc1", rob_bus.retire_pc, 12'h111);
        @(negedge clk);
        check("ooo_ret2", rob_bus.retire_valid, 1);
        check("ooo_pc2", rob_bus.retire_pc, 12'h112);
        @(negedge clk);
        check("ooo_done", rob_bus.retire_valid, 0);

        // Retirements that must not free: old_rd==0, then has_rd==0
        do_alloc(1'b1, 5'd6, 6'd40, 6'd0, 12'h120);
        do_alloc(1'b0, 5'd0, 6'd41, 6'd7, 12'h121);
        do_complete(4'd5);
        do_complete(4'd6);
        check("nofree_a_valid", rob_bus.retire_valid, 1);
        check("nofree_a_push", rob_bus.push_free_reg, 0);
        @(negedge clk);
        check("nofree_b_valid", rob_bus.retire_valid, 1);
        check("nofree_b_push", rob_bus.push_free_reg, 0);
        wait_drain("drain_nofree");

        // Full boundary
        pulse_reset();
        for (int i = 0; i < 16; i++)
            do_alloc(1'b1, 5'(i + 1), 6'(i + 16), 6'(i + 1), 12'(12'h200 + i));
        check("full_ready", rob_bus.alloc_ready, 0);
        check("full_count", rob_bus.count, 16);
        check("full_empty", rob_bus.empty, 0);
        rob_bus.alloc_valid = 1'b1;   // must be refused
        @(negedge clk);
        rob_bus.alloc_valid = 1'b0;
        check("full_refused", rob_bus.count, 16);
        do_complete(4'd0);
        check("full_retire_cycle_ready", rob_bus.alloc_ready, 0);
        check("full_retire_cycle_count", rob_bus.count, 16);
        @(negedge clk);
        check("full_recover_ready", rob_bus.alloc_ready, 1);
        check("full_recover_count", rob_bus.count, 15);
        for (int i = 1; i < 16; i++)
            do_complete(4'(i));
        wait_drain("drain_full");

        // Pipelined stream wrapping both pointers
        wraps    = 0;
        prev_idx = 4'd0;
        seen_idx = rob_bus.alloc_idx;
        for (int k = 0; k < 40; k++) begin
            if (k > 0 && seen_idx == 4'd15 && rob_bus.alloc_idx == 4'd0)
                wraps++;
            seen_idx = rob_bus.alloc_idx;
            if (k > 0) begin
                rob_bus.complete_valid = 1'b1;
                rob_bus.complete_idx   = prev_idx;
            end
            prev_idx = exp_tail[3:0];
            alloc_drive(1'b1, 5'(k % 31 + 1), 6'(k + 1), 6'(k % 60 + 1), 12'(12'h300 + k));
            @(negedge clk);
        end
        rob_bus.alloc_valid = 1'b0;
        do_complete(prev_idx);
        check("wrap_count", wraps, 2);
        wait_drain("drain_wrap");

        // Asynchronous reset with 5 entries pending and a retire pulse in flight
        head_model = exp_tail;
        for (int i = 0; i < 6; i++)
            do_alloc(1'b1, 5'(i + 10), 6'(i + 50), 6'(i + 20), 12'(12'h400 + i));
        do_complete(head_model[3:0]);
        @(negedge clk);
        check("pre_reset_retire", rob_bus.retire_valid, 1);
        check("pre_reset_count", rob_bus.count, 5);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_count", rob_bus.count, 0);
        check("async_empty", rob_bus.empty, 1);
        check("async_ready", rob_bus.alloc_ready, 1);
        check("async_idx", rob_bus.alloc_idx, 0);
        check("async_retire_valid", rob_bus.retire_valid, 0);
        check("async_push", rob_bus.push_free_reg, 0);
        check("async_freed", rob_bus.freed_reg, 0);
        check("async_rrd", rob_bus.retire_rrd, 0);
        check("async_areg", rob_bus.retire_areg, 0);
        check("async_pc", rob_bus.retire_pc, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_tail = 5'd0;
        do_complete(4'd2);   // stale entry: must be ignored
        repeat (3) @(negedge clk);
        check("post_reset_count", rob_bus.count, 0);

`ifdef ROB_FLUSH_EN
        // Flush with 5 pending; completion in the flush cycle is overridden
        head_model = exp_tail;
        for (int i = 0; i < 5; i++)
            do_alloc(1'b1, 5'(i + 1), 6'(i + 30), 6'(i + 40), 12'(12'h500 + i));
        do_complete(head_model[3:0]);
        flush = 1'b1;
        rob_bus.complete_valid = 1'b1;
        rob_bus.complete_idx   = head_model[3:0] + 4'd1;
        @(negedge clk);
        flush = 1'b0;
        rob_bus.complete_valid = 1'b0;
        sb.delete();
        check("flush_count", rob_bus.count, 0);
        check("flush_empty", rob_bus.empty, 1);
        check("flush_retire", rob_bus.retire_valid, 0);
        check("flush_push", rob_bus.push_free_reg, 0);
        repeat (3) begin
            @(negedge clk);
            check("flush_quiet", rob_bus.retire_valid, 0);
        end
        exp_tail = head_model;
        do_alloc(1'b1, 5'd2, 6'd44, 6'd12, 12'h600);
        do_complete(head_model[3:0]);
        wait_drain("drain_flush");
`endif

        repeat (2) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
